// File: rtl/ps2_host_tx_if.sv
// Host-side PS/2 transmit bundle: command handshake plus the open-drain pin levels and drives.
// master = environment (command source and pins), slave = the transmitter.
interface ps2_host_tx_if;
    logic [7:0] TxData;
    logic       TxStart;
    logic       Ready;
    logic       Done;
    logic       Error;
    logic       InCLK;
    logic       InData;
    logic       ClkDriveLow;
    logic       DataDriveLow;

    modport master (
        output TxData, TxStart, InCLK, InData,
        input  Ready, Done, Error, ClkDriveLow, DataDriveLow
    );

    modport slave (
        input  TxData, TxStart, InCLK, InData,
        output Ready, Done, Error, ClkDriveLow, DataDriveLow
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit odd-parity frame,
// device acknowledge, with a single shared down-counter for the inhibit and abort timers.
//
// state    | meaning
// IDLE     | ready for a command byte
// INHIBIT  | clock held low; data pulled low in the last cycle
// RTS      | clock released, start bit on data, waiting for first device clock
// BITS     | shifting data, parity and stop out on falling clocks
// ACK      | data released, waiting for the device acknowledge clock
// WAITIDLE | waiting for both lines to return high
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic          SampleCLK,
    input logic          RST_N,
    ps2_host_tx_if.slave bus
);
    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_RTS, S_BITS, S_ACK, S_WAITIDLE
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [9:0]    sr_q;
    logic [3:0]    bit_cnt_q;
    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic          clk_low_q, data_low_q;
    logic          ready_q, done_q, error_q;

    logic fall;
    logic timed_out;

    assign fall      = clk_prev_q & ~clk_sync_q;
    assign timed_out = (state_q inside {S_RTS, S_BITS, S_ACK, S_WAITIDLE}) && (cnt_q == '0);

    always_ff @(posedge SampleCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sr_q       <= '1;
            bit_cnt_q  <= '0;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            clk_meta_q <= bus.InCLK;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= bus.InData;
            dat_sync_q <= dat_meta_q;
            done_q     <= 1'b0;
            error_q    <= 1'b0;

            if (timed_out) begin
                clk_low_q  <= 1'b0;
                data_low_q <= 1'b0;
                error_q    <= 1'b1;
                ready_q    <= 1'b1;
                state_q    <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.TxStart) begin
                            sr_q       <= {1'b1, ~^bus.TxData, bus.TxData};
                            cnt_q      <= CW'(INHIBIT_CYCLES - 1);
                            clk_low_q  <= 1'b1;
                            // a one-cycle inhibit is its own final cycle
                            data_low_q <= (INHIBIT_CYCLES == 1);
                            ready_q    <= 1'b0;
                            state_q    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (cnt_q == '0) begin
                            clk_low_q  <= 1'b0;
                            data_low_q <= 1'b1;
                            cnt_q      <= CW'(TIMEOUT_CYCLES - 1);
                            bit_cnt_q  <= '0;
                            state_q    <= S_RTS;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                            if (cnt_q == CW'(1)) data_low_q <= 1'b1;
                        end
                    end
                    S_RTS: begin
                        cnt_q <= cnt_q - 1'b1;
                        if (fall) begin
                            data_low_q <= ~sr_q[0];
                            sr_q       <= {1'b1, sr_q[9:1]};
                            bit_cnt_q  <= 4'd1;
                            state_q    <= S_BITS;
                        end
                    end
                    S_BITS: begin
                        cnt_q <= cnt_q - 1'b1;
                        if (fall) begin
                            data_low_q <= ~sr_q[0];
                            sr_q       <= {1'b1, sr_q[9:1]};
                            // tenth fall puts the stop bit (released line) out
                            if (bit_cnt_q == 4'd9) state_q <= S_ACK;
                            else                   bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    S_ACK: begin
                        cnt_q      <= cnt_q - 1'b1;
                        data_low_q <= 1'b0;
                        if (fall) begin
                            if (!dat_sync_q) begin
                                state_q <= S_WAITIDLE;
                            end else begin
                                error_q <= 1'b1;
                                ready_q <= 1'b1;
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_WAITIDLE: begin
                        cnt_q <= cnt_q - 1'b1;
                        if (clk_sync_q && dat_sync_q) begin
                            done_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.Ready        = ready_q;
    assign bus.Done         = done_q;
    assign bus.Error        = error_q;
    assign bus.ClkDriveLow  = clk_low_q;
    assign bus.DataDriveLow = data_low_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: PS/2 device model on open-drain lines, frame scoreboard, outcome counters.
module tb_ps2_host_tx;
    logic SampleCLK;
    logic RST_N;
    logic dev_clk;
    logic dev_dat_low;
    int   n_cmp, n_bad;
    int   done_cnt, err_cnt;
    logic [10:0] exp_q[$];

    ps2_host_tx_if ifc ();

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000)) dut (
        .SampleCLK (SampleCLK),
        .RST_N     (RST_N),
        .bus       (ifc.slave)
    );

    assign ifc.InCLK  = dev_clk & ~ifc.ClkDriveLow;
    assign ifc.InData = ~dev_dat_low & ~ifc.DataDriveLow;

    initial SampleCLK = 1'b0;
    always #5 SampleCLK = ~SampleCLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge SampleCLK) begin
        if (RST_N) begin
            if (ifc.Done) begin
                done_cnt++;
                chk("ready_in_done", ifc.Ready, 1);
            end
            if (ifc.Error) err_cnt++;
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10]   = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d, input bit push);
        @(negedge SampleCLK);
        ifc.TxData  = d;
        ifc.TxStart = 1'b1;
        if (push) exp_q.push_back(exp_frame(d));
        @(negedge SampleCLK);
        ifc.TxStart = 1'b0;
    endtask

    // device side: watch inhibit, then clock 11 bits, sampling before each fall
    task automatic dev_xfer(input bit ack, input bit chk_inh, output logic [10:0] frame);
        int n;
        frame = '0;
        n = 0;
        while (!ifc.ClkDriveLow && n < 500) begin @(negedge SampleCLK); n++; end
        if (n >= 500) chk("inhibit_seen", 0, 1);
        n = 0;
        while (ifc.ClkDriveLow && n < 500) begin @(negedge SampleCLK); n++; end
        if (chk_inh) chk("inhibit_len", n, 20);
        chk("rts_data_low", ifc.DataDriveLow, 1);
        repeat (5) @(negedge SampleCLK);
        for (int i = 0; i < 11; i++) begin
            frame[i] = ifc.InData;
            if (i == 10 && ack) begin
                dev_dat_low = 1'b1;
                repeat (3) @(negedge SampleCLK);
            end
            dev_clk = 1'b0;
            repeat (10) @(negedge SampleCLK);
            dev_clk = 1'b1;
            repeat (10) @(negedge SampleCLK);
        end
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ifc.Ready && n < 50) begin @(negedge SampleCLK); n++; end
        chk("ready_back", ifc.Ready, 1);
    endtask

    task automatic score(input logic [10:0] got);
        if (exp_q.size() == 0) begin
            chk("sb_nonempty", 0, 1);
        end else begin
            chk("frame", got, exp_q.pop_front());
            chk("parity_odd", ^got[9:1], 1);
        end
    endtask

    task automatic full_tx(input logic [7:0] d, input bit ack);
        logic [10:0] fr;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(d, 1'b1);
        dev_xfer(ack, 1'b1, fr);
        score(fr);
        wait_ready();
        repeat (2) @(negedge SampleCLK);
        chk("done_delta", done_cnt - d0, ack ? 1 : 0);
        chk("err_delta", err_cnt - e0, ack ? 0 : 1);
        chk("clk_released", ifc.ClkDriveLow, 0);
        chk("data_released", ifc.DataDriveLow, 0);
    endtask

    initial begin
        logic [10:0] fr;
        int m, d0, e0;
        n_cmp = 0; n_bad = 0; done_cnt = 0; err_cnt = 0;
        dev_clk = 1'b1; dev_dat_low = 1'b0;
        ifc.TxData = 8'h00; ifc.TxStart = 1'b0;
        RST_N = 1'b0;
        repeat (3) @(negedge SampleCLK);
        chk("rst_ready", ifc.Ready, 1);
        chk("rst_clk_low", ifc.ClkDriveLow, 0);
        chk("rst_data_low", ifc.DataDriveLow, 0);
        chk("rst_done", ifc.Done, 0);
        chk("rst_error", ifc.Error, 0);
        RST_N = 1'b1;
        repeat (3) @(negedge SampleCLK);

        // 0xED with ack, then parity corner cases
        full_tx(8'hED, 1'b1);
        full_tx(8'h01, 1'b1);
        full_tx(8'hFF, 1'b1);

        // device does not acknowledge
        full_tx(8'h3A, 1'b0);

        // device never clocks: abort after the timeout
        e0 = err_cnt; d0 = done_cnt;
        start_tx(8'hA5, 1'b0);
        m = 0;
        while (ifc.ClkDriveLow !== 1'b0 && m < 100) begin @(negedge SampleCLK); m++; end
        m = 0;
        while (!ifc.Error && m < 3000) begin @(negedge SampleCLK); m++; end
        chk("tmo_cycles", m, 2000);
        chk("tmo_data_low", ifc.DataDriveLow, 0);
        chk("tmo_clk_low", ifc.ClkDriveLow, 0);
        repeat (2) @(negedge SampleCLK);
        chk("tmo_err_delta", err_cnt - e0, 1);
        chk("tmo_done_delta", done_cnt - d0, 0);
        chk("tmo_ready", ifc.Ready, 1);

        // TxStart mid-frame ignored; TxStart in the Done cycle accepted
        start_tx(8'hED, 1'b1);
        fork
            dev_xfer(1'b1, 1'b1, fr);
            begin
                repeat (80) @(negedge SampleCLK);
                ifc.TxData  = 8'h55;
                ifc.TxStart = 1'b1;
                @(negedge SampleCLK);
                ifc.TxStart = 1'b0;
            end
        join
        score(fr);
        ifc.TxData  = 8'h3C;
        ifc.TxStart = 1'b1;
        exp_q.push_back(exp_frame(8'h3C));
        m = 0;
        while (!ifc.Done && m < 50) begin @(negedge SampleCLK); m++; end
        chk("done_seen", ifc.Done, 1);
        @(negedge SampleCLK);
        ifc.TxStart = 1'b0;
        chk("accept_in_done_rdy", ifc.Ready, 0);
        chk("accept_in_done_clk", ifc.ClkDriveLow, 1);
        dev_xfer(1'b1, 1'b0, fr);
        score(fr);
        wait_ready();

        // reset during data bit 4 of 0xF4
        start_tx(8'hF4, 1'b0);
        m = 0;
        while (ifc.ClkDriveLow !== 1'b0 && m < 100) begin @(negedge SampleCLK); m++; end
        repeat (5) @(negedge SampleCLK);
        for (int k = 0; k < 5; k++) begin
            dev_clk = 1'b0;
            repeat (10) @(negedge SampleCLK);
            if (k < 4) begin
                dev_clk = 1'b1;
                repeat (10) @(negedge SampleCLK);
            end
        end
        chk("bit4_pre_rst", ifc.DataDriveLow, 0);
        chk("busy_pre_rst", ifc.Ready, 0);
        #3 RST_N = 1'b0;
        #1;
        chk("rst_mid_clk", ifc.ClkDriveLow, 0);
        chk("rst_mid_data", ifc.DataDriveLow, 0);
        chk("rst_mid_ready", ifc.Ready, 1);
        dev_clk = 1'b1;
        repeat (3) @(negedge SampleCLK);
        RST_N = 1'b1;
        repeat (5) @(negedge SampleCLK);
        chk("post_rst_ready", ifc.Ready, 1);
        full_tx(8'hF4, 1'b1);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
